// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit (AND/OR/XOR/NOR), CHUNK bits per clock, LSB chunk first.
// Optional zero-result accumulator enabled by defining SEQ_LOGIC_UNIT_ZERO_FLAG_EN.
module seq_logic_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(NCH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt_q;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_chunk, b_chunk, chunk;
  logic [WIDTH-1:0] mask, chunk_wide;

  // Select the active chunk of the latched operands and position the new bits in the result word.
  always_comb begin
    base       = 32'(cnt_q) * CHUNK;
    a_chunk    = CHUNK'(a_q >> base);
    b_chunk    = CHUNK'(b_q >> base);
    unique case (op_q)
      2'b00:   chunk = a_chunk & b_chunk;
      2'b01:   chunk = a_chunk | b_chunk;
      2'b10:   chunk = a_chunk ^ b_chunk;
      default: chunk = ~(a_chunk | b_chunk);
    endcase
    mask       = WIDTH'({CHUNK{1'b1}}) << base;
    chunk_wide = WIDTH'(chunk) << base;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 2'b00;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op;
            result   <= '0;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          result <= (result & ~mask) | chunk_wide;
          if (cnt_q == LastCnt) begin
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SEQ_LOGIC_UNIT_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_q <= 1'b0;
    end else if (state_q == StIdle && in_valid) begin
      zero_q <= 1'b1;
    end else if (state_q == StBusy) begin
      zero_q <= zero_q & (chunk == '0);
    end
  end

  assign zero = zero_q;
`else
  assign zero = 1'b0;
`endif

endmodule
